// File: rtl/user_strm_rr_arbiter_pkg.sv
// Shared Lynx types: stream widths, lane count and the arbiter state encoding.
package lynxTypes;

  localparam int AXI_DATA_BITS = 512;
  localparam int PID_BITS      = 6;
  localparam int N_STRM_AXI    = 4;
  localparam int N_USER_ARB_CH = N_STRM_AXI;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Lane index width; a single lane still needs one bit.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/user_rr_pick.sv
// Combinational round-robin pick: first requester after ptr_i, searching upward with wrap.
module user_rr_pick
  import lynxTypes::*;
#(
  parameter int N_CH    = 4,
  parameter int CH_BITS = ch_bits(N_CH)
) (
  input  logic [N_CH-1:0]    req_i,
  input  logic [CH_BITS-1:0] ptr_i,
  output logic [CH_BITS-1:0] grant_o,
  output logic               any_o
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    grant_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(ptr_i) + i) % N_CH;
      if (!any_o && req_i[idx]) begin
        grant_o = CH_BITS'(idx);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/user_strm_rr_arbiter.sv
// Packet-atomic round-robin merge of N_CH AXI4SR lanes into one registered stream.
// Optional per-lane packet counters are built when USER_ARB_STATS_EN is defined.
module user_strm_rr_arbiter
  import lynxTypes::*;
#(
  parameter int N_CH      = N_USER_ARB_CH,
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int ID_BITS   = PID_BITS,
  parameter int CH_BITS   = ch_bits(N_CH)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
`ifdef USER_ARB_STATS_EN
  input  logic                          stat_clr,
  output logic [N_CH*32-1:0]            stat_pkts,
`endif
  input  logic [N_CH*DATA_BITS-1:0]     s_tdata,
  input  logic [N_CH*DATA_BITS/8-1:0]   s_tkeep,
  input  logic [N_CH*ID_BITS-1:0]       s_tid,
  input  logic [N_CH-1:0]               s_tlast,
  input  logic [N_CH-1:0]               s_tvalid,
  output logic [N_CH-1:0]               s_tready,
  output logic [DATA_BITS-1:0]          m_tdata,
  output logic [DATA_BITS/8-1:0]        m_tkeep,
  output logic [ID_BITS-1:0]            m_tid,
  output logic                          m_tlast,
  output logic [CH_BITS-1:0]            m_tch,
  output logic                          m_tvalid,
  input  logic                          m_tready
);

  localparam int KEEP_BITS = DATA_BITS / 8;

  arb_state_t           state_q, state_d;
  logic [CH_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_BITS-1:0]   grant_q, grant_d;
  logic [CH_BITS-1:0]   pick;
  logic                 any_req;
  logic                 out_free;
  logic                 accept;

  logic                 m_tvalid_q, m_tvalid_d;
  logic [DATA_BITS-1:0] m_tdata_q, m_tdata_d;
  logic [KEEP_BITS-1:0] m_tkeep_q, m_tkeep_d;
  logic [ID_BITS-1:0]   m_tid_q, m_tid_d;
  logic                 m_tlast_q, m_tlast_d;
  logic [CH_BITS-1:0]   m_tch_q, m_tch_d;

  user_rr_pick #(
    .N_CH    (N_CH),
    .CH_BITS (CH_BITS)
  ) u_pick (
    .req_i   (s_tvalid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick),
    .any_o   (any_req)
  );

  // Grant is only released by an accepted tlast, so packets never interleave.
  always_comb begin
    out_free = !m_tvalid_q || m_tready;
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    s_tready = '0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        s_tready[grant_q] = out_free;
        accept            = s_tvalid[grant_q] && out_free;
        if (accept && s_tlast[grant_q]) begin
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tid_d    = m_tid_q;
    m_tlast_d  = m_tlast_q;
    m_tch_d    = m_tch_q;
    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s_tdata[int'(grant_q)*DATA_BITS +: DATA_BITS];
      m_tkeep_d  = s_tkeep[int'(grant_q)*KEEP_BITS +: KEEP_BITS];
      m_tid_d    = s_tid[int'(grant_q)*ID_BITS +: ID_BITS];
      m_tlast_d  = s_tlast[grant_q];
      m_tch_d    = grant_q;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= CH_BITS'(N_CH - 1);
      grant_q    <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tid_q    <= '0;
      m_tlast_q  <= 1'b0;
      m_tch_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tid_q    <= m_tid_d;
      m_tlast_q  <= m_tlast_d;
      m_tch_q    <= m_tch_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tid    = m_tid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tch    = m_tch_q;

`ifdef USER_ARB_STATS_EN
  logic [31:0] pkt_cnt_q [N_CH];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the counter array is small and software-visible, so unlike a data RAM it is reset.
      for (int i = 0; i < N_CH; i++) pkt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (stat_clr) begin
          pkt_cnt_q[i] <= '0;
        end else if (accept && s_tlast[grant_q] && (int'(grant_q) == i)) begin
          pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_stat
    assign stat_pkts[g*32 +: 32] = pkt_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_user_strm_rr_arbiter.sv
// Scoreboard bench for user_strm_rr_arbiter; stat counters are exercised when USER_ARB_STATS_EN is defined.
module tb_user_strm_rr_arbiter;
  import lynxTypes::*;

  localparam int N_CH      = 4;
  localparam int DATA_BITS = 64;
  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int ID_BITS   = 6;
  localparam int CH_BITS   = 2;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic [ID_BITS-1:0]   tid;
    logic                 last;
    int                   gap;
  } beat_t;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic [ID_BITS-1:0]   tid;
    logic                 last;
    logic [CH_BITS-1:0]   ch;
  } exp_t;

  logic                        aclk;
  logic                        aresetn;
  logic [N_CH*DATA_BITS-1:0]   s_tdata;
  logic [N_CH*KEEP_BITS-1:0]   s_tkeep;
  logic [N_CH*ID_BITS-1:0]     s_tid;
  logic [N_CH-1:0]             s_tlast;
  logic [N_CH-1:0]             s_tvalid;
  logic [N_CH-1:0]             s_tready;
  logic [DATA_BITS-1:0]        m_tdata;
  logic [KEEP_BITS-1:0]        m_tkeep;
  logic [ID_BITS-1:0]          m_tid;
  logic                        m_tlast;
  logic [CH_BITS-1:0]          m_tch;
  logic                        m_tvalid;
  logic                        m_tready;
`ifdef USER_ARB_STATS_EN
  logic                        stat_clr;
  logic [N_CH*32-1:0]          stat_pkts;
`endif

  beat_t src_q [N_CH][$];
  exp_t  sb [$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    pkt_id   = 0;
  int    cyc      = 0;
  int    last_cyc = 0;
  bit    after_last = 0;
  bit    gap_chk    = 0;

  user_strm_rr_arbiter #(
    .N_CH      (N_CH),
    .DATA_BITS (DATA_BITS),
    .ID_BITS   (ID_BITS),
    .CH_BITS   (CH_BITS)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
`ifdef USER_ARB_STATS_EN
    .stat_clr  (stat_clr),
    .stat_pkts (stat_pkts),
`endif
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tid     (s_tid),
    .s_tlast   (s_tlast),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tid     (m_tid),
    .m_tlast   (m_tlast),
    .m_tch     (m_tch),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Queue one packet on a lane and its expected output beats on the scoreboard.
  task automatic push_pkt(input int lane, input int tid, input int n, input int gap_at, input int gap_len);
    beat_t bt;
    exp_t  e;
    for (int b = 0; b < n; b++) begin
      bt.data = {$urandom, 8'(lane), 8'(pkt_id), 16'(b)};
      bt.keep = KEEP_BITS'($urandom);
      bt.tid  = ID_BITS'(tid);
      bt.last = (b == n - 1);
      bt.gap  = (b == gap_at) ? gap_len : 0;
      src_q[lane].push_back(bt);
      e.data = bt.data;
      e.keep = bt.keep;
      e.tid  = bt.tid;
      e.last = bt.last;
      e.ch   = CH_BITS'(lane);
      sb.push_back(e);
    end
    pkt_id++;
  endtask

  task automatic wait_drain();
    int pend;
    for (int k = 0; k < 300; k++) begin
      @(negedge aclk);
      pend = sb.size();
      for (int i = 0; i < N_CH; i++) pend += src_q[i].size();
      if (pend == 0) break;
    end
    check("drain_sb", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (m_tvalid) break;
    end
    check("wait_valid", 64'(m_tvalid), 64'd1);
  endtask

  // Lane drivers: retire beats accepted on the previous edge, then present the next one.
  initial begin
    logic [N_CH-1:0] f;
    beat_t b;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tid    = '0;
    forever begin
      @(negedge aclk);
      f = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < N_CH; i++) begin
        if (f[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        if (src_q[i].size() > 0) begin
          b = src_q[i][0];
          if (b.gap > 0) begin
            b.gap--;
            src_q[i][0] = b;
          end else begin
            s_tvalid[i] = 1'b1;
            s_tlast[i]  = b.last;
            s_tdata[i*DATA_BITS +: DATA_BITS] = b.data;
            s_tkeep[i*KEEP_BITS +: KEEP_BITS] = b.keep;
            s_tid[i*ID_BITS +: ID_BITS]       = b.tid;
          end
        end
      end
    end
  end

  // Output monitor: every transferred beat must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      cyc++;
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("m_tdata", 64'(m_tdata), 64'(e.data));
          check("m_tkeep", 64'(m_tkeep), 64'(e.keep));
          check("m_tid",   64'(m_tid),   64'(e.tid));
          check("m_tlast", 64'(m_tlast), 64'(e.last));
          check("m_tch",   64'(m_tch),   64'(e.ch));
          if (gap_chk && after_last) check("bubble", 64'(cyc - last_cyc), 64'd2);
          after_last = 1'b0;
          if (e.last) begin
            last_cyc   = cyc;
            after_last = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    aresetn  = 1'b0;
    m_tready = 1'b1;
`ifdef USER_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(negedge aclk);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tdata",  64'(m_tdata),  64'd0);
    check("rst_m_tch",    64'(m_tch),    64'd0);
    check("rst_m_tlast",  64'(m_tlast),  64'd0);
    aresetn = 1'b1;

    // Single lane 2 packet: two-cycle latency, other lanes never ready.
    @(posedge aclk);
    push_pkt(2, 5, 3, -1, 0);
    @(negedge aclk);
    check("t1_idle_ready", 64'(s_tready), 64'd0);
    check("t1_lat_c0", 64'(m_tvalid), 64'd0);
    @(negedge aclk);
    check("t1_lock_ready", 64'(s_tready), 64'b0100);
    check("t1_lat_c1", 64'(m_tvalid), 64'd0);
    @(negedge aclk);
    check("t1_lat_c2", 64'(m_tvalid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("t1_other_ready", 64'(s_tready & 4'b1011), 64'd0);
      @(negedge aclk);
    end
    wait_drain();

    // Park rr_ptr on lane 3, then all lanes offer 2-beat packets together.
    @(posedge aclk);
    push_pkt(3, 1, 1, -1, 0);
    wait_drain();
    @(posedge aclk);
    after_last = 1'b0;
    gap_chk    = 1'b1;
    push_pkt(0, 10, 2, -1, 0);
    push_pkt(1, 11, 2, -1, 0);
    push_pkt(2, 12, 2, -1, 0);
    push_pkt(3, 13, 2, -1, 0);
    push_pkt(0, 14, 2, -1, 0);
    wait_drain();
    gap_chk = 1'b0;

    // Downstream backpressure mid-packet.
    @(posedge aclk);
    push_pkt(1, 20, 5, -1, 0);
    wait_valid();
    @(posedge aclk);
    #1 m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check("t3_sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb[0];
        check("t3_hold_data", 64'(m_tdata), 64'(e.data));
      end
      check("t3_hold_valid", 64'(m_tvalid), 64'd1);
      check("t3_ready_low", 64'(s_tready), 64'd0);
    end
    @(posedge aclk);
    #1 m_tready = 1'b1;
    wait_drain();

    // Granted lane 1 stalls mid-packet; lane 0 must wait for its tlast.
    @(posedge aclk);
    push_pkt(0, 30, 1, -1, 0);
    wait_drain();
    @(posedge aclk);
    push_pkt(1, 31, 4, 2, 3);
    push_pkt(0, 32, 2, -1, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      check("t4_lane0_starved", 64'(s_tready[0]), 64'd0);
    end
    wait_drain();

    // Asynchronous reset in the middle of a lane 3 packet.
    @(posedge aclk);
    push_pkt(3, 40, 6, -1, 0);
    wait_valid();
    @(negedge aclk);
    #2 aresetn = 1'b0;
    src_q[3].delete();
    sb.delete();
    #1;
    check("t5_rst_valid", 64'(m_tvalid), 64'd0);
    check("t5_rst_ready", 64'(s_tready), 64'd0);
    check("t5_rst_data",  64'(m_tdata),  64'd0);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    push_pkt(0, 41, 2, -1, 0);
    push_pkt(1, 42, 2, -1, 0);
    wait_drain();

`ifdef USER_ARB_STATS_EN
    @(posedge aclk);
    #1 stat_clr = 1'b1;
    @(posedge aclk);
    #1 stat_clr = 1'b0;
    @(negedge aclk);
    check("stat_clr_only", 64'(stat_pkts[32 +: 32]), 64'd0);
    for (int p = 0; p < 7; p++) begin
      @(posedge aclk);
      push_pkt(1, 50 + p, 1, -1, 0);
      wait_drain();
    end
    check("stat_seven", 64'(stat_pkts[32 +: 32]), 64'd7);
    @(posedge aclk);
    push_pkt(1, 60, 1, -1, 0);
    @(posedge aclk);
    #1 stat_clr = 1'b1;
    @(posedge aclk);
    #1 stat_clr = 1'b0;
    @(negedge aclk);
    check("stat_clr_wins", 64'(stat_pkts[32 +: 32]), 64'd0);
    wait_drain();
`endif

    repeat (2) @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/user_strm_rr_arbiter.md
Name: user_strm_rr_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges N_CH AXI4SR host-sink streams into one AXI4SR stream feeding a user kernel port.
- Replaces the fixed single-lane mapping of the host sink mux (only lane 0 used) in the user wrapper with a parametrised N-lane merge.
- Also reports which lane each beat came from.
- Sits inside the user wrapper, between the per-lane stream array and the user logic instance.

Parameters:
- N_CH, 4, number of input lanes (1..16)
- DATA_BITS, AXI_DATA_BITS (512), tdata width; tkeep width is DATA_BITS/8
- ID_BITS, PID_BITS (6), tid width
- CH_BITS, $clog2(N_CH) with minimum 1, lane index width

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_tdata  in  N_CH*DATA_BITS  lane data; lane i occupies slice i
- s_tkeep  in  N_CH*DATA_BITS/8  lane byte enables
- s_tid  in  N_CH*ID_BITS  lane process id
- s_tlast  in  N_CH  end of packet
- s_tvalid  in  N_CH  lane valid
- s_tready  out  N_CH  lane ready
- m_tdata  out  DATA_BITS  merged data
- m_tkeep  out  DATA_BITS/8  merged keep
- m_tid  out  ID_BITS  passed-through tid
- m_tlast  out  1  passed-through tlast
- m_tch  out  CH_BITS  source lane of the current beat
- m_tvalid  out  1  merged valid
- m_tready  in  1  downstream ready

Behaviour:
- Reset (asynchronous on aresetn low, released synchronously to aclk):
  - state=IDLE, rr_ptr=N_CH-1, grant=0.
  - m_tvalid=0, s_tready=0.
  - m_tdata/m_tkeep/m_tid/m_tlast/m_tch=0.
- States:
  - IDLE: s_tready all 0. If any s_tvalid, grant = first set lane searching (rr_ptr+1) mod N_CH upward with wrap; next state=LOCK. If no lane is valid, stay in IDLE.
  - LOCK: s_tready[grant] = !m_tvalid || m_tready; all other lanes' s_tready=0.
    - On an accepted beat (s_tvalid[grant] && s_tready[grant]), load the output register with that lane's fields and m_tch=grant.
    - If the accepted beat has tlast=1: rr_ptr<=grant and next state=IDLE.
- Output register:
  - m_tvalid clears when m_tready=1 and no new beat is accepted that cycle.
  - Output fields hold stable while m_tvalid && !m_tready.
- Latency and throughput:
  - A beat valid in IDLE at cycle t appears on m_* at t+2.
  - Within a packet: one beat per cycle.
  - Exactly one idle bubble on the lane side between packets (the IDLE cycle).
- Grant is held until tlast is accepted, even if s_tvalid[grant] drops mid-packet. Other lanes starve meanwhile; this is intended.
- Single-beat packet (tlast on first beat): returns to IDLE after that one beat.
- N_CH=1: arbitration is degenerate; lane 0 is always granted, still with one bubble per packet.
- rr_ptr wraps from N_CH-1 to 0. All lanes valid continuously gives grant order 0,1,2,...,N_CH-1,0.
- Reset asserted mid-packet: the partial packet is dropped and the output register is cleared. No recovery of the packet.
- m_tch changes only on accepted beats.

Optional Feature:
- Macro USER_ARB_STATS_EN.
- Defined:
  - Adds output stat_pkts, width N_CH*32: one wrapping packet counter per lane, incremented on each accepted tlast beat of that lane.
  - Adds input stat_clr, width 1: synchronous clear of all counters. A clear in the same cycle as an increment wins (count=0).
  - Counters reset to 0.
- Not defined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package lynxTypes already provides AXI_DATA_BITS and PID_BITS.
- Add to lynxTypes:
  - typedef arb_state_t {IDLE, LOCK}
  - constant N_USER_ARB_CH = N_STRM_AXI
- One sub-module: user_rr_pick, combinational. Inputs: request vector and rr_ptr. Outputs: grant index and any-valid flag. Reused by the future card-stream merge.

Test Plan:
- Reset then a 3-beat packet on lane 2 only (tid=5) -> m_tch=2, m_tid=5 for 3 beats, first beat at cycle t+2, m_tlast on beat 3, s_tready[0,1,3]=0 throughout.
- All 4 lanes each offering 2-beat packets back-to-back -> output lane order 0,1,2,3,0; exactly one bubble cycle between packets; no beat interleaving.
- m_tready held 0 for 5 cycles mid-packet -> m_* stable, s_tready[grant]=0, no beat lost or duplicated; counts match after release.
- Granted lane 1 drops s_tvalid for 3 cycles mid-packet while lane 0 stays valid -> lane 0 not served until lane 1 tlast; lane 0 granted next.
- aresetn pulsed low asynchronously mid-packet on lane 3 -> m_tvalid=0 within the same cycle; after release, a lane 0 packet is granted first (rr_ptr=3).
- With USER_ARB_STATS_EN: 7 packets on lane 1, then stat_clr coinciding with an 8th tlast -> lane 1 count=7 before the clear, 0 after.
